// File: rtl/pic_int_pkg.sv
// Shared types and constants for the PIC16-style interrupt controller.
// Contents: FSM state enum, register addresses, INTCON bit positions,
// and the default interrupt vector address.
package pic_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] INTCON_A = 2'd0;
  localparam logic [1:0] IE_A     = 2'd1;
  localparam logic [1:0] IF_A     = 2'd2;

  localparam int GIE_B = 7;
  localparam int ACT_B = 6;

  localparam logic [10:0] VECTOR_DEF = 11'h004;

endpackage

// File: rtl/int_edge_det.sv
// Rising-edge detector for one interrupt source: registers the level and
// pulses rise_o for the cycle in which the level goes 0 -> 1.
// Ports: clk, rst (async high), lvl_i (synchronous level), rise_o (pulse).
module int_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  output logic rise_o
);

  logic prev_q;

  // prev resets low, so a level already high at reset release counts as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/pic_int_ctrl.sv
// Vectored interrupt controller: edge-captured flags, per-source and global
// enables, lowest-index priority, request/ack/RETFIE handshake with the core.
// Ports: clk, rst, irq_in, reg_we/addr/wdata/rdata, insn_boundary, int_ack,
// retfie, int_req, vector, int_id, active.
module pic_int_ctrl
  import pic_int_pkg::*;
#(
  parameter int          N_SRC  = 4,
  parameter logic [10:0] VECTOR = VECTOR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  input  logic             insn_boundary,
  input  logic             int_ack,
  input  logic             retfie,
  output logic             int_req,
  output logic [10:0]      vector,
  output logic [2:0]       int_id,
  output logic             active
);

  state_t           state_q;
  logic             gie_q;
  logic [N_SRC-1:0] ie_q, ie_d;
  logic [N_SRC-1:0] if_q, if_d;
  logic [2:0]       int_id_q;
  logic             int_req_q;
  logic             active_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req_vec;
  logic             pending;
  logic [2:0]       win_id;
  logic             wr_intcon, wr_gie_clr;
  logic             wdata_unused;

  assign wdata_unused = ^reg_wdata;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    int_edge_det u_det (
      .clk    (clk),
      .rst    (rst),
      .lvl_i  (irq_in[g]),
      .rise_o (rise[g])
    );
  end

  assign wr_intcon  = reg_we && (reg_addr == INTCON_A);
  assign wr_gie_clr = wr_intcon && !reg_wdata[GIE_B];

  // Hardware edge is OR'd in after the software clear so a new edge wins.
  always_comb begin
    ie_d = ie_q;
    if_d = if_q;
    if (reg_we && reg_addr == IE_A) ie_d = reg_wdata[N_SRC-1:0];
    if (reg_we && reg_addr == IF_A) if_d = if_q & reg_wdata[N_SRC-1:0];
    if_d = if_d | rise;
  end

  assign req_vec = if_q & ie_q;
  assign pending = |req_vec;

  // Scan downward so the last hit is the lowest set index.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) win_id = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gie_q     <= 1'b0;
      ie_q      <= '0;
      if_q      <= '0;
      int_id_q  <= '0;
      int_req_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      ie_q <= ie_d;
      if_q <= if_d;
      if (wr_intcon) gie_q <= reg_wdata[GIE_B];
      // FSM updates below override a same-cycle software GIE write.
      case (state_q)
        IDLE: begin
          if (gie_q && pending && insn_boundary) begin
            int_id_q  <= win_id;
            int_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            gie_q     <= 1'b0;
            int_req_q <= 1'b0;
            active_q  <= 1'b1;
            state_q   <= SERVICE;
          end else if (!gie_q || wr_gie_clr || !pending) begin
            int_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        SERVICE: begin
          if (retfie) begin
            gie_q    <= 1'b1;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          int_req_q <= 1'b0;
          active_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      INTCON_A: begin
        reg_rdata[GIE_B] = gie_q;
        reg_rdata[ACT_B] = active_q;
        reg_rdata[2:0]   = int_id_q;
      end
      IE_A:    reg_rdata[N_SRC-1:0] = ie_q;
      IF_A:    reg_rdata[N_SRC-1:0] = if_q;
      default: reg_rdata = '0;
    endcase
  end

  assign int_req = int_req_q;
  assign active  = active_q;
  assign int_id  = int_id_q;
  assign vector  = VECTOR;

endmodule

// File: tb/tb_pic_int_ctrl.sv
// Testbench for pic_int_ctrl: directed stimulus, a behavioural model checked
// every cycle, and literal expectations at the key points of the sequence.
module tb_pic_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        insn_boundary, int_ack, retfie;
  logic        int_req, active;
  logic [10:0] vector;
  logic [2:0]  int_id;

  int checks = 0;
  int errors = 0;

  pic_int_ctrl #(.N_SRC(4), .VECTOR(11'h004)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .insn_boundary(insn_boundary), .int_ack(int_ack), .retfie(retfie),
    .int_req(int_req), .vector(vector), .int_id(int_id), .active(active)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 requesting, 2 in handler.
  int         m_ph;
  bit         m_gie;
  logic [3:0] m_ie, m_if, m_prev;
  logic [2:0] m_id;

  task automatic model_reset();
    m_ph = 0; m_gie = 0; m_ie = '0; m_if = '0; m_prev = '0; m_id = '0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {m_gie, (m_ph == 2), 3'b000, m_id};
      2'd1:    return {4'h0, m_ie};
      2'd2:    return {4'h0, m_if};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("int_req", int_req, (m_ph == 1));
    chk("active", active, (m_ph == 2));
    chk("int_id", int_id, m_id);
    chk("vector", vector, 11'h004);
    chk("rdata", reg_rdata, m_read(reg_addr));
  endtask

  // Compute the model's next state from the inputs, clock once, compare.
  task automatic step();
    logic [3:0] rise, if_n, ie_n;
    logic [2:0] id_n;
    bit gie_n, pend;
    int ph_n;
    rise = irq_in & ~m_prev;
    if_n = m_if; ie_n = m_ie; gie_n = m_gie; ph_n = m_ph; id_n = m_id;
    if (reg_we) begin
      if (reg_addr == 2'd0) gie_n = reg_wdata[7];
      if (reg_addr == 2'd1) ie_n = reg_wdata[3:0];
      if (reg_addr == 2'd2) if_n = m_if & reg_wdata[3:0];
    end
    if_n = if_n | rise;
    pend = (m_if & m_ie) != 4'h0;
    if (m_ph == 0) begin
      if (m_gie && pend && insn_boundary) begin ph_n = 1; id_n = 3'(lowest(m_if & m_ie)); end
    end else if (m_ph == 1) begin
      if (int_ack) begin ph_n = 2; gie_n = 0; end
      else if (!gie_n || !pend) ph_n = 0;
    end else if (retfie) begin
      ph_n = 0; gie_n = 1;
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_if = if_n; m_ie = ie_n; m_gie = gie_n; m_ph = ph_n; m_id = id_n; m_prev = irq_in;
    end
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1; reg_addr = a; reg_wdata = d;
    step();
    reg_we = 0;
  endtask

  initial begin
    rst = 1; irq_in = 4'b0100; reg_we = 0; reg_addr = 2'd2; reg_wdata = 8'h00;
    insn_boundary = 0; int_ack = 0; retfie = 0;
    model_reset();
    step(); step();
    chk("reset_if", reg_rdata, 8'h00);
    chk("reset_req", int_req, 1'b0);

    // Held-high source flags on the first clock after release.
    rst = 0;
    step();
    chk("held_high_if", reg_rdata, 8'h04);
    step();
    chk("no_req_ie0", int_req, 1'b0);

    // Simultaneous edges on 1 and 3; lowest enabled index wins.
    wr(2'd1, 8'h0F);
    wr(2'd0, 8'h80);
    irq_in = 4'b1110; step();
    insn_boundary = 1; step(); insn_boundary = 0;
    chk("req_taken", int_req, 1'b1);
    chk("req_id1", int_id, 3'd1);
    step();
    chk("req_holds", int_req, 1'b1);
    int_ack = 1; step(); int_ack = 0;
    reg_addr = 2'd0; #1;
    chk("ack_intcon", reg_rdata, 8'h41);

    // In service: new flag, boundary ignored.
    irq_in = 4'b1111; insn_boundary = 1; step(); insn_boundary = 0;
    chk("svc_no_req", int_req, 1'b0);
    reg_addr = 2'd2; #1;
    chk("svc_if", reg_rdata, 8'h0F);
    wr(2'd2, 8'hFD);
    retfie = 1; step(); retfie = 0;
    reg_addr = 2'd0; #1;
    chk("retfie_intcon", reg_rdata, 8'h81);
    insn_boundary = 1; step(); insn_boundary = 0;
    chk("req2", int_req, 1'b1);
    chk("req2_id0", int_id, 3'd0);

    // Software GIE clear while requesting withdraws the request.
    wr(2'd0, 8'h00);
    chk("withdraw", int_req, 1'b0);
    reg_addr = 2'd2; #1;
    chk("withdraw_if", reg_rdata, 8'h0D);
    insn_boundary = 1; step(); insn_boundary = 0;
    chk("idle_gie0", int_req, 1'b0);

    // Plain clear, then clear racing a new edge.
    wr(2'd2, 8'hFB);
    chk("if_clear", reg_rdata, 8'h09);
    irq_in = 4'b1011; step();
    irq_in = 4'b1111; wr(2'd2, 8'hFB);
    chk("if_edge_wins", reg_rdata, 8'h0D);

    // Ack arriving with a GIE clear: ack wins.
    wr(2'd0, 8'h80);
    insn_boundary = 1; step(); insn_boundary = 0;
    chk("req3", int_req, 1'b1);
    int_ack = 1; wr(2'd0, 8'h00); int_ack = 0;
    chk("ack_beats_clr", active, 1'b1);

    // Asynchronous reset mid-service, checked before any clock edge.
    #1 rst = 1;
    #1;
    chk("arst_active", active, 1'b0);
    chk("arst_req", int_req, 1'b0);
    reg_addr = 2'd0; #1; chk("arst_intcon", reg_rdata, 8'h00);
    reg_addr = 2'd1; #1; chk("arst_ie", reg_rdata, 8'h00);
    reg_addr = 2'd2; #1; chk("arst_if", reg_rdata, 8'h00);
    model_reset();
    irq_in = 4'b0000;
    step();
    rst = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
